// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and sequencer controls shared by the stopwatch controller and its datapath.
// The master side is the controller: it reads the raw buttons and drives every control output.
interface stopwatch_ctrl_if #(
    parameter int LAP_AW = 3
);
    logic              fStart;
    logic              fStop;
    logic              fRecord;
    logic              o_Tick;
    logic              o_Clr;
    logic              o_LapWr;
    logic [LAP_AW-1:0] o_LapAddr;
    logic [LAP_AW:0]   o_LapCnt;
    logic              o_Full;
    logic              o_ShowLap;
    logic [1:0]        o_State;

    modport master (
        input  fStart, fStop, fRecord,
        output o_Tick, o_Clr, o_LapWr, o_LapAddr, o_LapCnt, o_Full, o_ShowLap, o_State
    );

    modport slave (
        output fStart, fStop, fRecord,
        input  o_Tick, o_Clr, o_LapWr, o_LapAddr, o_LapCnt, o_Full, o_ShowLap, o_State
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive the IDLE/RUN/PAUSE/REVIEW FSM and the count tick.
// Press event 2+DEB_CYC cycles after a button falls, outputs registered one cycle later; no backpressure.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500_000,
    parameter int DEB_CYC  = 500_000,
    parameter int LAP_AW   = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    stopwatch_ctrl_if.master sw
);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int CW = LAP_AW + 1;
    localparam int B_REC   = 0;
    localparam int B_STOP  = 1;
    localparam int B_START = 2;
    localparam logic [LAP_AW:0] LAPS = {1'b1, {LAP_AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSE  = 2'b10,
        REVIEW = 2'b11
    } state_t;

    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    armed;
    logic [2:0]    press;
    logic [DW-1:0] low_cnt  [3];
    logic [DW-1:0] high_cnt [3];

    logic ev_start;
    logic ev_stop;
    logic ev_rec;

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     pcnt;
    logic [PW-1:0]     pcnt_nx;
    logic [LAP_AW:0]   lap_cnt;
    logic [LAP_AW:0]   lap_cnt_nx;
    logic [LAP_AW-1:0] rptr;
    logic [LAP_AW-1:0] rptr_nx;
    logic [LAP_AW-1:0] lap_addr;
    logic [LAP_AW-1:0] addr_nx;
    logic              tick;
    logic              tick_nx;
    logic              clr;
    logic              clr_nx;
    logic              lap_wr;
    logic              wr_nx;
    logic              full;
    logic              show_lap;

    assign btn_raw = {sw.fStart, sw.fStop, sw.fRecord};

    // Synchronisers reset to the released level so reset exit never looks like a press.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1 <= '1;
            sync2 <= '1;
            armed <= '1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                low_cnt[i]  <= '0;
                high_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i]) begin
                    low_cnt[i] <= '0;
                    if (high_cnt[i] == DW'(DEB_CYC - 1)) armed[i] <= 1'b1;
                    if (high_cnt[i] != DW'(DEB_CYC)) high_cnt[i] <= high_cnt[i] + DW'(1);
                end else begin
                    high_cnt[i] <= '0;
                    if (low_cnt[i] != DW'(DEB_CYC)) low_cnt[i] <= low_cnt[i] + DW'(1);
                    if (low_cnt[i] == DW'(DEB_CYC - 1) && armed[i]) begin
                        press[i] <= 1'b1;
                        armed[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign ev_stop  = press[B_STOP];
    assign ev_start = press[B_START] & ~press[B_STOP];
    assign ev_rec   = press[B_REC] & ~press[B_STOP] & ~press[B_START];

    always_comb begin
        state_nx   = state;
        pcnt_nx    = pcnt;
        lap_cnt_nx = lap_cnt;
        rptr_nx    = rptr;
        addr_nx    = lap_cnt[LAP_AW-1:0];
        tick_nx    = 1'b0;
        clr_nx     = 1'b0;
        wr_nx      = 1'b0;

        if (ev_stop) begin
            state_nx   = IDLE;
            lap_cnt_nx = '0;
            rptr_nx    = '0;
            clr_nx     = 1'b1;
        end else if (ev_start) begin
            case (state)
                IDLE:    state_nx = RUN;
                RUN:     state_nx = PAUSE;
                PAUSE:   state_nx = RUN;
                REVIEW:  state_nx = PAUSE;
                default: state_nx = IDLE;
            endcase
        end else if (ev_rec) begin
            case (state)
                RUN: begin
                    if (!full) begin
                        wr_nx      = 1'b1;
                        lap_cnt_nx = lap_cnt + CW'(1);
                    end
                end
                PAUSE: begin
                    if (lap_cnt != '0) begin
                        state_nx = REVIEW;
                        rptr_nx  = '0;
                    end
                end
                REVIEW: begin
                    rptr_nx = ({1'b0, rptr} == lap_cnt - CW'(1)) ? '0 : rptr + LAP_AW'(1);
                end
                default: ;
            endcase
        end

        // Prescaler only advances across a RUN->RUN edge, so the pause edge holds the interval.
        if (state_nx == IDLE) begin
            pcnt_nx = '0;
        end else if (state == RUN && state_nx == RUN) begin
            pcnt_nx = (pcnt == PW'(TICK_DIV - 1)) ? '0 : pcnt + PW'(1);
            tick_nx = (pcnt_nx == PW'(TICK_DIV - 1));
        end

        // During a write strobe the address still shows the slot being written.
        if (ev_stop) begin
            addr_nx = '0;
        end else if (state_nx == REVIEW) begin
            addr_nx = rptr_nx;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            lap_cnt  <= '0;
            rptr     <= '0;
            lap_addr <= '0;
            tick     <= 1'b0;
            clr      <= 1'b0;
            lap_wr   <= 1'b0;
            full     <= 1'b0;
            show_lap <= 1'b0;
        end else begin
            state    <= state_nx;
            pcnt     <= pcnt_nx;
            lap_cnt  <= lap_cnt_nx;
            rptr     <= rptr_nx;
            lap_addr <= addr_nx;
            tick     <= tick_nx;
            clr      <= clr_nx;
            lap_wr   <= wr_nx;
            full     <= (lap_cnt_nx == LAPS);
            show_lap <= (state_nx == REVIEW);
        end
    end

    assign sw.o_Tick    = tick;
    assign sw.o_Clr     = clr;
    assign sw.o_LapWr   = lap_wr;
    assign sw.o_LapAddr = lap_addr;
    assign sw.o_LapCnt  = lap_cnt;
    assign sw.o_Full    = full;
    assign sw.o_ShowLap = show_lap;
    assign sw.o_State   = state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: press-schedule reference model checked every cycle, table of press steps,
// and hand sequences for tick timing, pause/resume, simultaneous events and asynchronous reset.
module tb_stopwatch_ctrl;
    localparam int TD = 5;
    localparam int DC = 4;
    localparam int AW = 2;
    localparam int LAPS = 4;
    localparam int HOLD = 8;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_REVIEW = 3;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    stopwatch_ctrl_if #(.LAP_AW(AW)) sw ();

    stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYC(DC), .LAP_AW(AW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .sw  (sw.master)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode, stored laps, review slot, RUN cycles elapsed since last clear.
    int   m_state, m_cnt, m_rptr, m_run;
    logic e_tick, e_clr, e_wr;
    int   e_addr;

    int tick_idx[$];
    int chg_idx[$];
    int wr_seen, clr_seen;

    typedef struct {
        logic [2:0] btn;   // {start, stop, record}
        int len;
        int st;
        int cnt;
        int full;
        int show;
        int addr;
        int nwr;
    } row_t;
    row_t rows[20];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {sw.o_Tick, sw.o_Clr, sw.o_LapWr, sw.o_LapAddr, sw.o_LapCnt,
                sw.o_Full, sw.o_ShowLap, sw.o_State};
    endfunction

    function automatic logic [11:0] expv();
        logic [1:0] a;
        logic [2:0] c;
        logic [1:0] s;
        a = 2'(e_addr);
        c = 3'(m_cnt);
        s = 2'(m_state);
        return {e_tick, e_clr, e_wr, a, c, (m_cnt == LAPS), (m_state == S_REVIEW), s};
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_cnt = 0; m_rptr = 0; m_run = 0;
        e_tick = 0; e_clr = 0; e_wr = 0; e_addr = 0;
    endtask

    task automatic model_edge(input logic [2:0] ev);
        int ns;
        int wr_addr;
        ns = m_state; wr_addr = 0;
        e_tick = 0; e_clr = 0; e_wr = 0;
        if (ev[1]) begin
            ns = S_IDLE; m_cnt = 0; m_rptr = 0; m_run = 0; e_clr = 1;
        end else if (ev[2]) begin
            ns = (m_state == S_IDLE || m_state == S_PAUSE) ? S_RUN : S_PAUSE;
        end else if (ev[0]) begin
            if (m_state == S_RUN && m_cnt < LAPS) begin
                e_wr = 1; wr_addr = m_cnt; m_cnt++;
            end else if (m_state == S_PAUSE && m_cnt > 0) begin
                ns = S_REVIEW; m_rptr = 0;
            end else if (m_state == S_REVIEW) begin
                m_rptr = (m_rptr + 1) % m_cnt;
            end
        end
        if (m_state == S_RUN && ns == S_RUN) begin
            m_run++;
            e_tick = ((m_run % TD) == TD - 1);
        end
        m_state = ns;
        if (e_wr) e_addr = wr_addr % LAPS;
        else if (m_state == S_REVIEW) e_addr = m_rptr;
        else e_addr = m_cnt % LAPS;
    endtask

    task automatic cycle(input logic [2:0] raw, input logic [2:0] ev);
        sw.fStart  = ~raw[2];
        sw.fStop   = ~raw[1];
        sw.fRecord = ~raw[0];
        @(posedge Clk);
        model_edge(ev);
        #1;
        check($sformatf("cycle@%0t", $time), int'(obs()), int'(expv()));
    endtask

    // Buttons held for len cycles then released for hold cycles; a press of at least DC cycles
    // reaches the FSM on the (DC+3)th edge after the first low sample.
    task automatic press(input logic [2:0] btn, input int len, input int hold);
        int prev;
        tick_idx.delete(); chg_idx.delete(); wr_seen = 0; clr_seen = 0;
        prev = int'(sw.o_State);
        for (int i = 1; i <= len + hold; i++) begin
            cycle((i <= len) ? btn : 3'b000, (len >= DC && i == DC + 3) ? btn : 3'b000);
            if (sw.o_Tick) tick_idx.push_back(i);
            if (int'(sw.o_State) != prev) chg_idx.push_back(i);
            prev = int'(sw.o_State);
            wr_seen += int'(sw.o_LapWr);
            clr_seen += int'(sw.o_Clr);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000, 3'b000);
    endtask

    task automatic do_reset();
        sw.fStart = 1'b1; sw.fStop = 1'b1; sw.fRecord = 1'b1;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        check("rst_outputs", int'(obs()), 0);
        Rst = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            press(rows[i].btn, rows[i].len, HOLD);
            check($sformatf("row%0d_state", i), int'(sw.o_State), rows[i].st);
            check($sformatf("row%0d_cnt", i), int'(sw.o_LapCnt), rows[i].cnt);
            check($sformatf("row%0d_full", i), int'(sw.o_Full), rows[i].full);
            check($sformatf("row%0d_show", i), int'(sw.o_ShowLap), rows[i].show);
            check($sformatf("row%0d_addr", i), int'(sw.o_LapAddr), rows[i].addr);
            check($sformatf("row%0d_wr", i), wr_seen, rows[i].nwr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, w, late, seen;
        logic [2:0] b;
        int r, len, hold;

        //              btn     len state     cnt full show addr nwr
        rows[0]  = '{3'b100, 3, S_IDLE,   0, 0, 0, 0, 0};
        rows[1]  = '{3'b001, 5, S_RUN,    1, 0, 0, 1, 1};
        rows[2]  = '{3'b001, 5, S_RUN,    2, 0, 0, 2, 1};
        rows[3]  = '{3'b001, 5, S_RUN,    3, 0, 0, 3, 1};
        rows[4]  = '{3'b001, 5, S_RUN,    4, 1, 0, 0, 1};
        rows[5]  = '{3'b001, 5, S_RUN,    4, 1, 0, 0, 0};
        rows[6]  = '{3'b100, 5, S_PAUSE,  4, 1, 0, 0, 0};
        rows[7]  = '{3'b001, 5, S_REVIEW, 4, 1, 1, 0, 0};
        rows[8]  = '{3'b001, 6, S_REVIEW, 4, 1, 1, 1, 0};
        rows[9]  = '{3'b001, 5, S_REVIEW, 4, 1, 1, 2, 0};
        rows[10] = '{3'b001, 7, S_REVIEW, 4, 1, 1, 3, 0};
        rows[11] = '{3'b001, 5, S_REVIEW, 4, 1, 1, 0, 0};
        rows[12] = '{3'b100, 5, S_PAUSE,  4, 1, 0, 0, 0};
        rows[13] = '{3'b100, 5, S_RUN,    4, 1, 0, 0, 0};
        rows[14] = '{3'b100, 5, S_RUN,    0, 0, 0, 0, 0};
        rows[15] = '{3'b001, 5, S_IDLE,   0, 0, 0, 0, 0};
        rows[16] = '{3'b100, 4, S_RUN,    0, 0, 0, 0, 0};
        rows[17] = '{3'b100, 5, S_PAUSE,  0, 0, 0, 0, 0};
        rows[18] = '{3'b001, 5, S_PAUSE,  0, 0, 0, 0, 0};
        rows[19] = '{3'b010, 5, S_IDLE,   0, 0, 0, 0, 0};

        sw.fStart = 1'b1; sw.fStop = 1'b1; sw.fRecord = 1'b1;
        model_reset();
        #1;
        do_reset();

        // Short press gives no event.
        run_rows(0, 0);
        check("t2_no_tick", tick_idx.size(), 0);

        // Long Start press from reset: one event, RUN after edge 7, ticks every TD cycles.
        do_reset();
        press(3'b100, 10, 12);
        check("t1_one_event", chg_idx.size(), 1);
        check("t1_run_edge", (chg_idx.size() > 0) ? chg_idx[0] : -1, DC + 3);
        check("t1_first_tick", (tick_idx.size() > 0) ? tick_idx[0] : -1, DC + 3 + TD - 1);
        check("t1_tick_period", (tick_idx.size() > 1) ? tick_idx[1] - tick_idx[0] : -1, TD);

        // Lap records until full, then one more that must be dropped.
        run_rows(1, 5);

        // Pause with the prescaler at 2, then resume: tick must land 2 cycles after resuming.
        p0 = m_run % TD;
        w = ((2 - p0 - (DC + 2)) % TD + TD) % TD;
        idle(w);
        press(3'b100, 5, HOLD);
        check("t4_paused", int'(sw.o_State), S_PAUSE);
        late = 0;
        foreach (tick_idx[k]) if (tick_idx[k] > DC + 3) late++;
        check("t4_no_tick_paused", late, 0);
        idle(6);
        press(3'b100, 5, HOLD);
        check("t4_resumed", int'(sw.o_State), S_RUN);
        check("t4_resume_tick", (tick_idx.size() > 0) ? tick_idx[0] : -1, DC + 3 + 2);

        // Review walk with wrap, then back through PAUSE to RUN.
        run_rows(6, 13);

        // Start and Stop events in the same cycle: Stop wins.
        press(3'b110, 5, HOLD);
        check("t5_clr_pulses", clr_seen, 1);
        check("t5_state", int'(sw.o_State), S_IDLE);
        check("t5_cnt", int'(sw.o_LapCnt), 0);
        check("t5_full", int'(sw.o_Full), 0);

        // Asynchronous reset between ticks while running.
        run_rows(14, 14);
        seen = 0;
        for (int j = 0; j < 2 * TD && seen == 0; j++) begin
            cycle(3'b000, 3'b000);
            if (sw.o_Tick) seen = 1;
        end
        check("t6_tick_seen", seen, 1);
        cycle(3'b000, 3'b000);
        #2;
        Rst = 1'b1;
        #1;
        check("t6_async_outputs", int'(obs()), 0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
        idle(8);
        check("t6_post_state", int'(sw.o_State), S_IDLE);

        // Record ignored in IDLE and in PAUSE with no laps; Stop returns to IDLE.
        run_rows(15, 19);

        // Random press schedule against the model, including overlapping buttons.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 99);
            if (r < 10) b = 3'b010;
            else if (r < 40) b = 3'b100;
            else if (r < 85) b = 3'b001;
            else b = 3'($urandom_range(1, 7));
            len = $urandom_range(1, 9);
            hold = $urandom_range(8, 12);
            press(b, len, hold);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
